// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer for the 5-stage RISC-V core: load-use stalls, data-memory
// freezes, branch/jump redirects, sticky error flags and saturating counters.
module hazard_stall_controller #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_branch_i,
  input  logic        ex_taken_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_target_i,
  input  logic        dmem_busy_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_write_o,
  output logic        exmem_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        pc_sel_o,
  output logic [31:0] pc_target_o,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0]  LU_INIT  = 2'(LOAD_USE_STALLS - 1);
  localparam logic [16:0] WAIT_MAX = 17'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  state_e      resume_q, resume_d;
  state_e      eff_state;
  logic [1:0]  lu_cnt_q, lu_cnt_d;
  logic [16:0] wait_cnt_q, wait_cnt_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        rs1_match, rs2_match;
  logic        hazard, redirect;

  assign rs1_match = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_match = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  assign hazard    = ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);
  assign redirect  = (ex_branch_i && ex_taken_i) || ex_jump_i;

  // Once memory releases, MEM_WAIT behaves exactly like the state it interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_write_o  = 1'b0;
    exmem_write_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    pc_sel_o      = 1'b0;
    pc_target_o   = 32'd0;
    state_d       = state_q;
    resume_d      = resume_q;
    lu_cnt_d      = lu_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    misalign_d    = misalign_q;
    timeout_d     = timeout_q;
    flush_cnt_d   = flush_cnt_q;
    if (!reset) begin
      if (dmem_busy_i) begin
        state_d = MEM_WAIT;
        if (state_q != MEM_WAIT) resume_d = state_q;
        if (wait_cnt_q < WAIT_MAX) wait_cnt_d = wait_cnt_q + 17'd1;
        if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
      end else begin
        wait_cnt_d = 17'd0;
        state_d    = eff_state;
        if (redirect) begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          idex_write_o  = 1'b1;
          exmem_write_o = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
          pc_sel_o      = 1'b1;
          pc_target_o   = {ex_target_i[31:1], 1'b0};
          state_d       = RUN;
          lu_cnt_d      = 2'd0;
          if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
          if (ex_target_i[1]) misalign_d = 1'b1;
        end else if (eff_state == LU_STALL || hazard) begin
          // Freeze PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
          idex_write_o  = 1'b1;
          exmem_write_o = 1'b1;
          idex_flush_o  = 1'b1;
          if (eff_state == LU_STALL) begin
            lu_cnt_d = lu_cnt_q - 2'd1;
            state_d  = (lu_cnt_q == 2'd1) ? RUN : LU_STALL;
          end else if (LOAD_USE_STALLS > 1) begin
            lu_cnt_d = LU_INIT;
            state_d  = LU_STALL;
          end else begin
            state_d = RUN;
          end
        end else begin
          pc_write_o    = 1'b1;
          ifid_write_o  = 1'b1;
          idex_write_o  = 1'b1;
          exmem_write_o = 1'b1;
          state_d       = RUN;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!reset && !pc_write_o && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      resume_q    <= RUN;
      lu_cnt_q    <= 2'd0;
      wait_cnt_q  <= 17'd0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      lu_cnt_q    <= lu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign misalign_o  = misalign_q;
  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: three instances (1, 2, 3 load-use stalls)
// driven in lockstep and checked against a cycle-level behavioural model.
module tb_hazard_stall_controller;

  localparam int TO = 256;
  localparam logic [6:0] CTL_RUN   = 7'b1111000;
  localparam logic [6:0] CTL_STALL = 7'b0011010;
  localparam logic [6:0] CTL_REDIR = 7'b1111111;
  localparam logic [6:0] CTL_OFF   = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        use1, use2, ld, br, tk, jmp, busy;
  logic [31:0] tgt;

  logic        pc_write_w[3], ifid_write_w[3], idex_write_w[3], exmem_write_w[3];
  logic        ifid_flush_w[3], idex_flush_w[3], pc_sel_w[3], misalign_w[3], timeout_w[3];
  logic [31:0] pc_target_w[3], stall_cnt_w[3], flush_cnt_w[3];

  int errors = 0;
  int checks = 0;

  // model state: remaining forced stall cycles, consecutive busy cycles, flags, counters
  int          stall_left[3];
  int          busy_run[3];
  logic        mis_m[3], to_m[3];
  logic [31:0] scnt_m[3], fcnt_m[3];

  logic [6:0]  exp_ctl[3];
  logic [31:0] exp_tgt[3], exp_scnt[3], exp_fcnt[3];
  logic        exp_mis[3], exp_to[3];
  logic [6:0]  exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_stall_controller #(.LOAD_USE_STALLS(g + 1), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .reset(reset),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
      .ex_mem_read_i(ld), .ex_rd_i(ex_rd), .ex_branch_i(br), .ex_taken_i(tk),
      .ex_jump_i(jmp), .ex_target_i(tgt), .dmem_busy_i(busy),
      .pc_write_o(pc_write_w[g]), .ifid_write_o(ifid_write_w[g]),
      .idex_write_o(idex_write_w[g]), .exmem_write_o(exmem_write_w[g]),
      .ifid_flush_o(ifid_flush_w[g]), .idex_flush_o(idex_flush_w[g]),
      .pc_sel_o(pc_sel_w[g]), .pc_target_o(pc_target_w[g]),
      .misalign_o(misalign_w[g]), .timeout_o(timeout_w[g]),
      .stall_cnt_o(stall_cnt_w[g]), .flush_cnt_o(flush_cnt_w[g])
    );
  end

  function automatic logic [6:0] act_ctl(int k);
    return {pc_write_w[k], ifid_write_w[k], idex_write_w[k], exmem_write_w[k],
            ifid_flush_w[k], idex_flush_w[k], pc_sel_w[k]};
  endfunction

  task automatic idle();
    reset = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; ld = 1'b0; br = 1'b0; tk = 1'b0; jmp = 1'b0;
    busy = 1'b0; tgt = 32'd0;
  endtask

  task automatic model_step();
    logic redirect, hazard;
    redirect = (br && tk) || jmp;
    hazard = ld && (ex_rd != 5'd0) && ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
    for (int k = 0; k < 3; k++) begin
      exp_mis[k] = mis_m[k]; exp_to[k] = to_m[k];
      exp_scnt[k] = scnt_m[k]; exp_fcnt[k] = fcnt_m[k];
      exp_ctl[k] = CTL_OFF; exp_tgt[k] = 32'd0;
      if (reset) begin
        stall_left[k] = 0; busy_run[k] = 0; mis_m[k] = 1'b0; to_m[k] = 1'b0;
        scnt_m[k] = 32'd0; fcnt_m[k] = 32'd0;
      end else if (busy) begin
        busy_run[k] = (busy_run[k] < TO) ? busy_run[k] + 1 : TO;
        if (busy_run[k] >= TO) to_m[k] = 1'b1;
        if (scnt_m[k] != 32'hFFFF_FFFF) scnt_m[k]++;
      end else begin
        busy_run[k] = 0;
        if (redirect) begin
          exp_ctl[k] = CTL_REDIR;
          exp_tgt[k] = tgt & 32'hFFFF_FFFE;
          if (fcnt_m[k] != 32'hFFFF_FFFF) fcnt_m[k]++;
          if (tgt[1]) mis_m[k] = 1'b1;
          stall_left[k] = 0;
        end else if (stall_left[k] > 0 || hazard) begin
          exp_ctl[k] = CTL_STALL;
          if (stall_left[k] > 0) stall_left[k]--;
          else stall_left[k] = k;  // this instance stalls k+1 cycles in total
          if (scnt_m[k] != 32'hFFFF_FFFF) scnt_m[k]++;
        end else begin
          exp_ctl[k] = CTL_RUN;
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1;
    sample(); advance();
    idle();
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; busy = 1'b1; br = 1'b1; tk = 1'b1; tgt = 32'h1234_5678;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_OFF) begin errors++; $display("FAIL reset_ctl inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_OFF); end
      checks++;
      if (pc_target_w[k] !== 32'd0) begin errors++; $display("FAIL reset_target inst=%0d got=%h exp=0", k, pc_target_w[k]); end
    end
    advance(); idle();
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_RUN) begin errors++; $display("FAIL after_reset_ctl inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_RUN); end
      checks++;
      if ({misalign_w[k], timeout_w[k], stall_cnt_w[k], flush_cnt_w[k]} !== 66'd0) begin
        errors++; $display("FAIL after_reset_regs inst=%0d got=%b%b %h %h exp=all zero", k, misalign_w[k], timeout_w[k], stall_cnt_w[k], flush_cnt_w[k]);
      end
    end
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    ld = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use1 = 1'b1;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_STALL) begin errors++; $display("FAIL lu_first inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_STALL); end
    end
    advance(); idle();
    for (int c = 1; c <= 3; c++) begin
      sample();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_ctl(k) !== ((c <= k) ? CTL_STALL : CTL_RUN)) begin
          errors++; $display("FAIL lu_follow c=%0d inst=%0d got=%b exp=%b", c, k, act_ctl(k), (c <= k) ? CTL_STALL : CTL_RUN);
        end
      end
      advance();
    end
    ld = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; use1 = 1'b1; id_rs2 = 5'd0; use2 = 1'b1;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall_cnt_w[k] !== 32'(k + 1)) begin errors++; $display("FAIL lu_stall_cnt inst=%0d got=%0d exp=%0d", k, stall_cnt_w[k], k + 1); end
      checks++;
      if (act_ctl(k) !== CTL_RUN) begin errors++; $display("FAIL lu_x0 inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_RUN); end
    end
    advance(); idle();
  endtask

  task automatic test_branch();
    do_reset();
    br = 1'b1; tk = 1'b1; tgt = 32'h0000_0103;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_REDIR) begin errors++; $display("FAIL br_ctl inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_REDIR); end
      checks++;
      if (pc_target_w[k] !== 32'h0000_0102) begin errors++; $display("FAIL br_target inst=%0d got=%h exp=00000102", k, pc_target_w[k]); end
    end
    advance();
    tk = 1'b0; tgt = 32'h0000_0204;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_RUN || pc_target_w[k] !== 32'd0) begin
        errors++; $display("FAIL br_not_taken inst=%0d got=%b/%h exp=%b/0", k, act_ctl(k), pc_target_w[k], CTL_RUN);
      end
      checks++;
      if (misalign_w[k] !== 1'b1 || flush_cnt_w[k] !== 32'd1) begin
        errors++; $display("FAIL br_flags inst=%0d got=%b/%0d exp=1/1", k, misalign_w[k], flush_cnt_w[k]);
      end
    end
    advance(); idle();
    jmp = 1'b1; tgt = 32'h0000_1001;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pc_target_w[k] !== 32'h0000_1000) begin errors++; $display("FAIL jal_target inst=%0d got=%h exp=00001000", k, pc_target_w[k]); end
    end
    advance(); idle();
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (flush_cnt_w[k] !== 32'd2) begin errors++; $display("FAIL jal_flush_cnt inst=%0d got=%0d exp=2", k, flush_cnt_w[k]); end
    end
    advance();
  endtask

  task automatic test_simultaneous();
    do_reset();
    ld = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; use2 = 1'b1; br = 1'b1; tk = 1'b1; tgt = 32'h40;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_REDIR) begin errors++; $display("FAIL sim_redirect inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_REDIR); end
    end
    advance(); idle();
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_RUN) begin errors++; $display("FAIL sim_after inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_RUN); end
    end
    advance();
    ld = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; use1 = 1'b1;
    sample(); advance(); idle();
    jmp = 1'b1; tgt = 32'h80;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_REDIR) begin errors++; $display("FAIL abort_redirect inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_REDIR); end
    end
    advance(); idle();
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_RUN) begin errors++; $display("FAIL abort_run inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_RUN); end
    end
    advance();
  endtask

  task automatic test_mem_freeze();
    do_reset();
    ld = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; use1 = 1'b1;
    sample(); advance(); idle();
    busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_ctl(k) !== CTL_OFF) begin errors++; $display("FAIL freeze_ctl c=%0d inst=%0d got=%b exp=%b", c, k, act_ctl(k), CTL_OFF); end
      end
      advance();
    end
    busy = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sample();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (act_ctl(k) !== ((c <= k) ? CTL_STALL : CTL_RUN)) begin
          errors++; $display("FAIL freeze_resume c=%0d inst=%0d got=%b exp=%b", c, k, act_ctl(k), (c <= k) ? CTL_STALL : CTL_RUN);
        end
      end
      advance();
    end
    busy = 1'b1;
    for (int i = 0; i < TO; i++) begin
      sample();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (timeout_w[k] !== 1'b0 || act_ctl(k) !== CTL_OFF) begin
          errors++; $display("FAIL timeout_early i=%0d inst=%0d got=%b/%b exp=0/%b", i, k, timeout_w[k], act_ctl(k), CTL_OFF);
        end
      end
      advance();
    end
    busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (timeout_w[k] !== 1'b1) begin errors++; $display("FAIL timeout_sticky c=%0d inst=%0d got=%b exp=1", c, k, timeout_w[k]); end
        checks++;
        if (stall_cnt_w[k] !== 32'(4 + k + TO)) begin
          errors++; $display("FAIL freeze_stall_cnt c=%0d inst=%0d got=%0d exp=%0d", c, k, stall_cnt_w[k], 4 + k + TO);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    jmp = 1'b1; tgt = 32'h6;
    sample(); advance(); idle();
    busy = 1'b1;
    sample(); advance(); sample(); advance();
    reset = 1'b1;
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_OFF || pc_target_w[k] !== 32'd0) begin
        errors++; $display("FAIL mid_reset_out inst=%0d got=%b/%h exp=%b/0", k, act_ctl(k), pc_target_w[k], CTL_OFF);
      end
      checks++;
      if (stall_cnt_w[k] !== exp_scnt[k] || misalign_w[k] !== 1'b1) begin
        errors++; $display("FAIL mid_reset_pre inst=%0d got=%0d/%b exp=%0d/1", k, stall_cnt_w[k], misalign_w[k], exp_scnt[k]);
      end
    end
    advance(); idle();
    sample();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (act_ctl(k) !== CTL_RUN) begin errors++; $display("FAIL mid_reset_run inst=%0d got=%b exp=%b", k, act_ctl(k), CTL_RUN); end
      checks++;
      if ({misalign_w[k], timeout_w[k], stall_cnt_w[k], flush_cnt_w[k]} !== 66'd0) begin
        errors++; $display("FAIL mid_reset_regs inst=%0d got=%b%b %h %h exp=all zero", k, misalign_w[k], timeout_w[k], stall_cnt_w[k], flush_cnt_w[k]);
      end
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 63) == 0);
      busy   = ($urandom_range(0, 7) == 0);
      ld     = $urandom_range(0, 1) == 1;
      ex_rd  = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      use1   = $urandom_range(0, 1) == 1;
      use2   = $urandom_range(0, 1) == 1;
      br     = ($urandom_range(0, 3) == 0);
      tk     = $urandom_range(0, 1) == 1;
      jmp    = ($urandom_range(0, 9) == 0);
      tgt    = $urandom;
      sample();
      for (int k = 0; k < 3; k++) exp_q.push_back(exp_ctl[k]);
      for (int k = 0; k < 3; k++) begin
        logic [6:0] e;
        e = exp_q.pop_front();
        checks++;
        if (act_ctl(k) !== e) begin errors++; $display("FAIL rnd_ctl n=%0d inst=%0d got=%b exp=%b", n, k, act_ctl(k), e); end
        checks++;
        if (pc_target_w[k] !== exp_tgt[k]) begin errors++; $display("FAIL rnd_target n=%0d inst=%0d got=%h exp=%h", n, k, pc_target_w[k], exp_tgt[k]); end
        checks++;
        if (stall_cnt_w[k] !== exp_scnt[k] || flush_cnt_w[k] !== exp_fcnt[k]) begin
          errors++; $display("FAIL rnd_counters n=%0d inst=%0d got=%0d/%0d exp=%0d/%0d", n, k, stall_cnt_w[k], flush_cnt_w[k], exp_scnt[k], exp_fcnt[k]);
        end
        checks++;
        if (misalign_w[k] !== exp_mis[k] || timeout_w[k] !== exp_to[k]) begin
          errors++; $display("FAIL rnd_flags n=%0d inst=%0d got=%b/%b exp=%b/%b", n, k, misalign_w[k], timeout_w[k], exp_mis[k], exp_to[k]);
        end
      end
      advance();
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      stall_left[k] = 0; busy_run[k] = 0; mis_m[k] = 1'b0; to_m[k] = 1'b0;
      scnt_m[k] = 32'd0; fcnt_m[k] = 32'd0;
    end
    idle(); reset = 1'b1;
    advance();
    test_reset();
    test_load_use();
    test_branch();
    test_simultaneous();
    test_mem_freeze();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
